nav_sequencer: RTL and testbench

- Command-level sequencer that drives the heading PID controller's inputs: moving, dsrd_hdng and frwrd_spd.
- Accepts one command at a time over a valid/ready handshake.
- Handles two motion commands:
  - Turn in place to an absolute heading, then wait for at_hdng.
  - Move forward a given number of squares, ramping speed up, counting line crossings, then ramping speed down.
- Sits between the command/UART layer and the PID block and pulses done when each command completes.

---
 rtl/nav_sequencer.sv | 146 ++++++++++++++
 tb/tb_nav_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nav_sequencer.sv
// Command sequencer feeding the heading PID: turn-to-heading and move-N-squares with speed ramps.
// Outputs are registered and update on the edge after acceptance; cmd_rdy is high only in IDLE, so new commands wait until the current one ends.
module nav_sequencer #(
  parameter logic [10:0] MIN_FRWRD = 11'h0D0,
  parameter logic [10:0] MAX_FRWRD = 11'h2A0,
  parameter logic [10:0] SPD_INC   = 11'h018
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic        hdng_vld,
  input  logic        at_hdng,
  input  logic        line_cross,
  output logic [11:0] dsrd_hdng,
  output logic        moving,
  output logic [10:0] frwrd_spd,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, TURN, RAMP, DECEL, FIN} state_t;

  localparam logic [3:0]  OP_HDNG     = 4'h2;
  localparam logic [3:0]  OP_MOVE     = 4'h4;
  localparam logic [10:0] DEC_STEP    = SPD_INC << 1;
  localparam logic [11:0] MAX12       = {1'b0, MAX_FRWRD};
  localparam logic [11:0] DECEL_FLOOR = {1'b0, MIN_FRWRD} + {1'b0, DEC_STEP};

  state_t      state, state_nxt;
  logic [11:0] hdng_nxt;
  logic        moving_nxt;
  logic [10:0] spd_nxt;
  logic [3:0]  squares, squares_nxt;
  logic [3:0]  sq_cnt, sq_cnt_nxt;
  logic        turn_armed, turn_armed_nxt;
  logic [2:0]  lc_sync;
  logic        cross_pulse;
  logic [11:0] ramp_sum;
  logic [3:0]  cnt_inc;

  // line_cross is asynchronous: two flops to resolve metastability, a third for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc_sync     <= 3'b000;
      cross_pulse <= 1'b0;
    end else begin
      lc_sync     <= {lc_sync[1:0], line_cross};
      cross_pulse <= lc_sync[1] & ~lc_sync[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dsrd_hdng  <= 12'h000;
      moving     <= 1'b0;
      frwrd_spd  <= 11'h000;
      squares    <= 4'h0;
      sq_cnt     <= 4'h0;
      turn_armed <= 1'b0;
    end else begin
      state      <= state_nxt;
      dsrd_hdng  <= hdng_nxt;
      moving     <= moving_nxt;
      frwrd_spd  <= spd_nxt;
      squares    <= squares_nxt;
      sq_cnt     <= sq_cnt_nxt;
      turn_armed <= turn_armed_nxt;
    end
  end

  assign ramp_sum = {1'b0, frwrd_spd} + {1'b0, SPD_INC};
  assign cnt_inc  = sq_cnt + {3'b000, cross_pulse};

  always_comb begin
    state_nxt      = state;
    hdng_nxt       = dsrd_hdng;
    moving_nxt     = moving;
    spd_nxt        = frwrd_spd;
    squares_nxt    = squares;
    sq_cnt_nxt     = sq_cnt;
    turn_armed_nxt = turn_armed;
    case (state)
      IDLE: begin
        if (cmd_vld) begin
          case (cmd[15:12])
            OP_HDNG: begin
              hdng_nxt       = cmd[11:0];
              moving_nxt     = 1'b1;
              spd_nxt        = 11'h000;
              turn_armed_nxt = 1'b0;
              state_nxt      = TURN;
            end
            OP_MOVE: begin
              if (cmd[3:0] != 4'h0) begin
                squares_nxt = cmd[3:0];
                sq_cnt_nxt  = 4'h0;
                moving_nxt  = 1'b1;
                spd_nxt     = MIN_FRWRD;
                state_nxt   = RAMP;
              end else begin
                state_nxt = FIN;
              end
            end
            default: state_nxt = FIN;
          endcase
        end
      end
      TURN: begin
        // first TURN cycle is blind so an at_hdng left over from the old heading cannot end the turn
        if (!turn_armed) begin
          turn_armed_nxt = 1'b1;
        end else if (at_hdng && hdng_vld) begin
          state_nxt = FIN;
        end
      end
      RAMP: begin
        if (hdng_vld) begin
          spd_nxt = (ramp_sum > MAX12) ? MAX_FRWRD : ramp_sum[10:0];
        end
        sq_cnt_nxt = cnt_inc;
        if (cnt_inc == squares) begin
          state_nxt = DECEL;
        end
      end
      DECEL: begin
        if (hdng_vld) begin
          if ({1'b0, frwrd_spd} <= DECEL_FLOOR) begin
            spd_nxt    = 11'h000;
            moving_nxt = 1'b0;
            state_nxt  = FIN;
          end else begin
            spd_nxt = frwrd_spd - DEC_STEP;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_rdy = (state == IDLE);
  assign done    = (state == FIN);

endmodule

// File: tb/tb_nav_sequencer.sv
// Randomized scoreboard bench for nav_sequencer: stimulus pushes expected speeds and completions, a monitor pops and compares.
module tb_nav_sequencer;

  localparam int MIN_S = 'h0D0;
  localparam int MAX_S = 'h2A0;
  localparam int INC_S = 'h018;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        hdng_vld;
  logic        at_hdng;
  logic        line_cross;
  logic [11:0] dsrd_hdng;
  logic        moving;
  logic [10:0] frwrd_spd;
  logic        done;

  always #5 clk = ~clk;

  nav_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .hdng_vld   (hdng_vld),
    .at_hdng    (at_hdng),
    .line_cross (line_cross),
    .dsrd_hdng  (dsrd_hdng),
    .moving     (moving),
    .frwrd_spd  (frwrd_spd),
    .done       (done)
  );

  typedef struct {
    logic [11:0] hdng;
    logic        mv;
    logic [10:0] spd;
  } done_exp_t;

  done_exp_t   exp_done[$];
  logic [10:0] exp_spd[$];
  int          checks = 0;
  int          errors = 0;

  // reference state of the commanded outputs
  logic [11:0] m_hdng;
  logic        m_mv;
  int          m_spd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare speed after every strobe and outputs at every done
  logic hv_q = 1'b0;
  logic prev_done = 1'b0;
  always @(posedge clk) hv_q <= hdng_vld;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hv_q) begin
        if (exp_spd.size() == 0) begin
          checks++; errors++;
          $display("FAIL spd_unexpected_strobe: got %0h expected no strobe", frwrd_spd);
        end else begin
          check("spd_on_strobe", {21'd0, frwrd_spd}, {21'd0, exp_spd.pop_front()});
        end
      end
      if (prev_done) begin
        check("done_width", {31'd0, done}, 32'd0);
        check("rdy_after_done", {31'd0, cmd_rdy}, 32'd1);
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done=1 expected 0 at %0t", $time);
        end else begin
          done_exp_t e;
          e = exp_done.pop_front();
          check("done_hdng", {20'd0, dsrd_hdng}, {20'd0, e.hdng});
          check("done_moving", {31'd0, moving}, {31'd0, e.mv});
          check("done_spd", {21'd0, frwrd_spd}, {21'd0, e.spd});
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe();
    hdng_vld = 1'b1;
    exp_spd.push_back(m_spd[10:0]);
    tick();
    hdng_vld = 1'b0;
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (!cmd_rdy && k < 400) begin
      tick();
      k++;
    end
    check("cmd_rdy_wait", {31'd0, cmd_rdy}, 32'd1);
  endtask

  task automatic issue(input logic [15:0] c);
    wait_rdy();
    cmd     = c;
    cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
    cmd     = 16'($urandom);
    check("rdy_drop", {31'd0, cmd_rdy}, 32'd0);
  endtask

  task automatic ramp_up();
    m_spd = (m_spd + INC_S > MAX_S) ? MAX_S : m_spd + INC_S;
  endtask

  task automatic do_turn(input logic [11:0] h, input int pre);
    m_hdng = h; m_mv = 1'b1; m_spd = 0;
    at_hdng = 1'b1;
    issue({4'h2, h});
    check("turn_hdng", {20'd0, dsrd_hdng}, {20'd0, h});
    check("turn_moving", {31'd0, moving}, 32'd1);
    check("turn_spd", {21'd0, frwrd_spd}, 32'd0);
    strobe();                       // lands on the first TURN cycle: no exit allowed
    for (int i = 0; i < pre; i++) begin
      at_hdng = 1'b0;
      idle($urandom_range(0, 2));
      strobe();
    end
    at_hdng = 1'b1;
    idle($urandom_range(0, 2));
    exp_done.push_back('{h, 1'b1, 11'd0});
    strobe();
    at_hdng = 1'b0;
    idle(2);
  endtask

  task automatic do_nop(input logic [15:0] c);
    exp_done.push_back('{m_hdng, m_mv, m_spd[10:0]});
    issue(c);
    check("nop_done_now", {31'd0, done}, 32'd1);
    check("nop_hdng", {20'd0, dsrd_hdng}, {20'd0, m_hdng});
    idle(2);
  endtask

  task automatic do_move(input int sq, input int nmax, input bit coincide, input bit poke);
    m_mv = 1'b1; m_spd = MIN_S;
    issue({12'h400, 4'(sq)});
    check("move_start_spd", {21'd0, frwrd_spd}, MIN_S);
    check("move_moving", {31'd0, moving}, 32'd1);
    if (poke) begin
      cmd = 16'h2ABC; cmd_vld = 1'b1;
    end
    for (int c = 1; c <= sq; c++) begin
      int n = $urandom_range(nmax / 2, nmax);
      for (int i = 0; i < n; i++) begin
        ramp_up();
        strobe();
        idle(3);
      end
      line_cross = 1'b1;
      if (c < sq) begin
        idle(3);
        if (coincide) begin
          ramp_up();
          strobe();
        end else begin
          idle(1);
        end
        idle(2); line_cross = 1'b0; idle(2);
      end else begin
        idle(6); line_cross = 1'b0; idle(3);
      end
    end
    cmd_vld = 1'b0;
    // decel: extra crossings must not matter
    for (int guard = 0; guard < 40; guard++) begin
      line_cross = ~line_cross;
      if (m_spd <= MIN_S + 2 * INC_S) begin
        m_spd = 0; m_mv = 1'b0;
        exp_done.push_back('{m_hdng, 1'b0, 11'd0});
        strobe();
        break;
      end
      m_spd = m_spd - 2 * INC_S;
      strobe();
      idle(3);
    end
    line_cross = 1'b0;
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd = 16'h0; cmd_vld = 1'b0; hdng_vld = 1'b0;
    at_hdng = 1'b0; line_cross = 1'b0;
    m_hdng = 12'h0; m_mv = 1'b0; m_spd = 0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("rst_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("rst_hdng", {20'd0, dsrd_hdng}, 32'd0);
    check("rst_moving", {31'd0, moving}, 32'd0);
    check("rst_spd", {21'd0, frwrd_spd}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    do_turn(12'h3FF, 0);
    do_move(2, 24, 1'b0, 1'b1);
    do_nop(16'h4000);
    do_nop(16'h7123);
    do_move(3, 4, 1'b1, 1'b0);

    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0: do_turn(12'($urandom), $urandom_range(0, 3));
        1: do_move($urandom_range(1, 4), $urandom_range(0, 6), 1'($urandom), 1'($urandom));
        default: begin
          logic [3:0] op;
          op = 4'($urandom);
          if (op == 4'h2 || op == 4'h4) op = 4'h9;
          do_nop({op, 12'($urandom)});
        end
      endcase
    end

    // abort a move mid-ramp with an asynchronous reset
    do_turn(12'h5A5, 1);
    m_mv = 1'b1; m_spd = MIN_S;
    issue(16'h4003);
    for (int i = 0; i < 3; i++) begin
      ramp_up();
      strobe();
      idle(3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("abort_hdng", {20'd0, dsrd_hdng}, 32'd0);
    check("abort_moving", {31'd0, moving}, 32'd0);
    check("abort_spd", {21'd0, frwrd_spd}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    exp_spd.delete();
    exp_done.delete();
    m_hdng = 12'h0; m_mv = 1'b0; m_spd = 0;
    idle(2);
    rst_n = 1'b1;
    idle(10);
    do_turn(12'h0C3, 0);
    do_move(1, 3, 1'b0, 1'b0);
    idle(5);

    check("spd_queue_empty", exp_spd.size(), 32'd0);
    check("done_queue_empty", exp_done.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
